// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN job transmitter.
//   - job buffer lengths and expected result count
//   - FSM state encoding
//   - host buffer-select encoding
//   - bit positions inside the sticky error vector
package cnn_pkg;

  localparam int IMG_LEN = 75;   // 3 channels x 5x5 image words
  localparam int KER_LEN = 12;   // words per kernel channel
  localparam int W_LEN   = 24;   // weight words
  localparam int OUT_LEN = 3;    // result words per job
  localparam int N_BANKS = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_RECV = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SEL_IMG  = 2'd0,
    SEL_KER1 = 2'd1,
    SEL_KER2 = 2'd2,
    SEL_W    = 2'd3
  } ld_sel_t;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_OVERLAP = 1;
  localparam int ERR_GAP     = 2;

  // Number of valid words in the bank addressed by a given ld_sel value.
  function automatic int bank_len(input int sel);
    case (sel)
      0:       return IMG_LEN;
      1, 2:    return KER_LEN;
      default: return W_LEN;
    endcase
  endfunction

endpackage

// File: rtl/cnn_job_buf.sv
// Four-bank job buffer (image, kernel ch1, kernel ch2, weights).
// Ports:
//   clk                  system clock
//   wr_en/wr_sel/wr_addr/wr_data  host write port; out-of-range addresses dropped
//   rd_idx               stream index shared by all banks
//   rd_img/rd_ker1/rd_ker2/rd_w   combinational read data, 0 beyond bank length
// A read of the address being written in the same cycle returns the new
// data, so a job launched together with a write streams the fresh word.
module cnn_job_buf
  import cnn_pkg::*;
(
  input  logic        clk,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [6:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [6:0]  rd_idx,
  output logic [31:0] rd_img,
  output logic [31:0] rd_ker1,
  output logic [31:0] rd_ker2,
  output logic [31:0] rd_w
);

  logic [N_BANKS-1:0][31:0] rd_word;

  for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_bank
    localparam int         LEN  = bank_len(gi);
    localparam int         AW   = $clog2(LEN);
    localparam logic [6:0] LEN7 = 7'(LEN);

    logic [31:0] mem [LEN];
    logic        wr_hit;

    assign wr_hit = wr_en && (wr_sel == 2'(gi)) && (wr_addr < LEN7);

    always_ff @(posedge clk) begin
      if (wr_hit) begin
        mem[wr_addr[AW-1:0]] <= wr_data;
      end
    end

    assign rd_word[gi] = (rd_idx >= LEN7)                  ? 32'd0   :
                         (wr_hit && (wr_addr == rd_idx))   ? wr_data :
                                                             mem[rd_idx[AW-1:0]];
  end

  assign rd_img  = rd_word[0];
  assign rd_ker1 = rd_word[1];
  assign rd_ker2 = rd_word[2];
  assign rd_w    = rd_word[3];

endmodule

// File: rtl/cnn_job_tx.sv
// Transmit-side sequencer for the CNN accelerator.
// Buffers one job from the host, streams it onto the CNN input bus with
// registered outputs, then collects and checks the result burst.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ld_en/ld_sel/ld_addr/ld_data    host buffer write port (IDLE only)
//   ld_opt, start                   option bit and launch pulse
//   busy, done, err                 job status; err is sticky until next start
//   in_valid/Img/Kernel_ch1/Kernel_ch2/Weight/Opt   CNN input bus
//   out_valid/out                   CNN result bus
//   res_valid/res_idx/res_data      captured result words, one cycle after arrival
module cnn_job_tx
  import cnn_pkg::*;
#(
  parameter int LAT_MAX = 150
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_en,
  input  logic [1:0]  ld_sel,
  input  logic [6:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic        ld_opt,
  input  logic        start,
  output logic        busy,
  output logic        in_valid,
  output logic [31:0] Img,
  output logic [31:0] Kernel_ch1,
  output logic [31:0] Kernel_ch2,
  output logic [31:0] Weight,
  output logic        Opt,
  input  logic        out_valid,
  input  logic [31:0] out,
  output logic        res_valid,
  output logic [1:0]  res_idx,
  output logic [31:0] res_data,
  output logic        done,
  output logic [2:0]  err
);

  localparam logic [6:0] K_LAST   = 7'(IMG_LEN - 1);
  localparam logic [7:0] LAT_LAST = 8'(LAT_MAX - 1);
  localparam logic [1:0] W_LAST   = 2'(OUT_LEN - 1);
  localparam logic [1:0] W_FULL   = 2'(OUT_LEN);

  state_t      state_reg, state_next;
  logic [6:0]  k_reg, k_next;          // index of the word currently on the bus
  logic [7:0]  lat_reg, lat_next;
  logic [1:0]  wcnt_reg, wcnt_next;    // result words captured so far
  logic [2:0]  err_reg, err_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        in_valid_reg, in_valid_next;
  logic [31:0] img_reg, img_next;
  logic [31:0] ker1_reg, ker1_next;
  logic [31:0] ker2_reg, ker2_next;
  logic [31:0] w_reg, w_next;
  logic        opt_reg, opt_next;
  logic        res_valid_reg, res_valid_next;
  logic [1:0]  res_idx_reg, res_idx_next;
  logic [31:0] res_data_reg, res_data_next;

  logic        load_word;
  logic        capture;
  logic        finish;

  logic [6:0]  rd_idx;
  logic [31:0] rd_img, rd_ker1, rd_ker2, rd_w;

  // While streaming, fetch the word for the next cycle; from IDLE the
  // first word (index 0) is fetched so it appears right after start.
  assign rd_idx = (state_reg == ST_SEND) ? (k_reg + 7'd1) : 7'd0;

  cnn_job_buf u_buf (
    .clk     (clk),
    .wr_en   (ld_en && (state_reg == ST_IDLE)),
    .wr_sel  (ld_sel),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_idx  (rd_idx),
    .rd_img  (rd_img),
    .rd_ker1 (rd_ker1),
    .rd_ker2 (rd_ker2),
    .rd_w    (rd_w)
  );

  always_comb begin
    state_next     = state_reg;
    k_next         = k_reg;
    lat_next       = lat_reg;
    wcnt_next      = wcnt_reg;
    err_next       = err_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    in_valid_next  = 1'b0;
    img_next       = '0;
    ker1_next      = '0;
    ker2_next      = '0;
    w_next         = '0;
    opt_next       = 1'b0;
    res_valid_next = 1'b0;
    res_idx_next   = res_idx_reg;
    res_data_next  = res_data_reg;
    load_word      = 1'b0;
    capture        = 1'b0;
    finish         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SEND;
          busy_next  = 1'b1;
          err_next   = '0;
          k_next     = '0;
          wcnt_next  = '0;
          load_word  = 1'b1;
          opt_next   = ld_opt;
        end
      end
      ST_SEND: begin
        if (out_valid) begin
          // Result traffic while we are still streaming: abort the job.
          err_next[ERR_OVERLAP] = 1'b1;
          finish                = 1'b1;
        end else if (k_reg == K_LAST) begin
          state_next = ST_WAIT;
          lat_next   = '0;
        end else begin
          k_next    = k_reg + 7'd1;
          load_word = 1'b1;
        end
      end
      ST_WAIT: begin
        if (out_valid) begin
          capture = 1'b1;
        end else if (lat_reg == LAT_LAST) begin
          // Counter would reach LAT_MAX on this edge with no reply.
          err_next[ERR_TIMEOUT] = 1'b1;
          finish                = 1'b1;
        end else begin
          lat_next = lat_reg + 8'd1;
        end
      end
      ST_RECV: begin
        if (out_valid) begin
          capture = 1'b1;
        end else begin
          err_next[ERR_GAP] = 1'b1;
          finish            = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        // A word right after a complete burst is an overrun; it is flagged
        // but never presented on the result port.
        if (out_valid && (wcnt_reg == W_FULL)) begin
          err_next[ERR_GAP] = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (load_word) begin
      in_valid_next = 1'b1;
      img_next      = rd_img;
      ker1_next     = rd_ker1;
      ker2_next     = rd_ker2;
      w_next        = rd_w;
    end

    if (capture) begin
      res_valid_next = 1'b1;
      res_data_next  = out;
      res_idx_next   = wcnt_reg;
      wcnt_next      = wcnt_reg + 2'd1;
      if (wcnt_reg == W_LAST) begin
        finish = 1'b1;
      end else begin
        state_next = ST_RECV;
      end
    end

    if (finish) begin
      state_next = ST_DONE;
      busy_next  = 1'b0;
      done_next  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      k_reg         <= '0;
      lat_reg       <= '0;
      wcnt_reg      <= '0;
      err_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      in_valid_reg  <= 1'b0;
      img_reg       <= '0;
      ker1_reg      <= '0;
      ker2_reg      <= '0;
      w_reg         <= '0;
      opt_reg       <= 1'b0;
      res_valid_reg <= 1'b0;
      res_idx_reg   <= '0;
      res_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      k_reg         <= k_next;
      lat_reg       <= lat_next;
      wcnt_reg      <= wcnt_next;
      err_reg       <= err_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      in_valid_reg  <= in_valid_next;
      img_reg       <= img_next;
      ker1_reg      <= ker1_next;
      ker2_reg      <= ker2_next;
      w_reg         <= w_next;
      opt_reg       <= opt_next;
      res_valid_reg <= res_valid_next;
      res_idx_reg   <= res_idx_next;
      res_data_reg  <= res_data_next;
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign in_valid   = in_valid_reg;
  assign Img        = img_reg;
  assign Kernel_ch1 = ker1_reg;
  assign Kernel_ch2 = ker2_reg;
  assign Weight     = w_reg;
  assign Opt        = opt_reg;
  assign res_valid  = res_valid_reg;
  assign res_idx    = res_idx_reg;
  assign res_data   = res_data_reg;

endmodule

// File: tb/tb_cnn_job_tx.sv
// Self-checking bench for cnn_job_tx. The expected timeline of every job
// (stream words, result words, done cycle, error code) is computed from the
// job parameters with plain arithmetic against a copy of the buffer contents.
module tb_cnn_job_tx;
  import cnn_pkg::*;

  localparam int LAT_MAX = 150;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_en = 1'b0;
  logic [1:0]  ld_sel = '0;
  logic [6:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ld_opt = 1'b0;
  logic        start = 1'b0;
  logic        out_valid = 1'b0;
  logic [31:0] out_word = '0;
  logic        busy, in_valid, Opt, res_valid, done;
  logic [31:0] Img, Kernel_ch1, Kernel_ch2, Weight, res_data;
  logic [1:0]  res_idx;
  logic [2:0]  err;

  cnn_job_tx #(.LAT_MAX(LAT_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_en      (ld_en),
    .ld_sel     (ld_sel),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_opt     (ld_opt),
    .start      (start),
    .busy       (busy),
    .in_valid   (in_valid),
    .Img        (Img),
    .Kernel_ch1 (Kernel_ch1),
    .Kernel_ch2 (Kernel_ch2),
    .Weight     (Weight),
    .Opt        (Opt),
    .out_valid  (out_valid),
    .out        (out_word),
    .res_valid  (res_valid),
    .res_idx    (res_idx),
    .res_data   (res_data),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference copy of the job buffers.
  logic [31:0] m_img [IMG_LEN];
  logic [31:0] m_k1  [KER_LEN];
  logic [31:0] m_k2  [KER_LEN];
  logic [31:0] m_w   [W_LEN];
  logic [31:0] resp  [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int sel, input int addr, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_sel  = 2'(sel);
    ld_addr = 7'(addr);
    ld_data = data;
    @(posedge clk);
    @(negedge clk);
    ld_en = 1'b0;
    case (sel)
      0: if (addr < IMG_LEN) m_img[addr] = data;
      1: if (addr < KER_LEN) m_k1[addr]  = data;
      2: if (addr < KER_LEN) m_k2[addr]  = data;
      default: if (addr < W_LEN) m_w[addr] = data;
    endcase
  endtask

  task automatic load_buffers(input bit pattern);
    for (int k = 0; k < IMG_LEN; k++) load(0, k, pattern ? 32'(k) : $urandom());
    for (int k = 0; k < KER_LEN; k++) load(1, k, pattern ? 32'h100 + 32'(k) : $urandom());
    for (int k = 0; k < KER_LEN; k++) load(2, k, pattern ? 32'h200 + 32'(k) : $urandom());
    for (int k = 0; k < W_LEN; k++)   load(3, k, pattern ? 32'h300 + 32'(k) : $urandom());
    // Out-of-range writes must not alias onto low addresses.
    load(1, 16, $urandom());
    load(2, 12, $urandom());
    load(3, 32, $urandom());
    load(0, 100, $urandom());
  endtask

  // lat: cycles from the first in_valid-low cycle to the first reply word
  // nw: reply words (0 = none), ovl: stream cycle of an early reply (-1 none)
  // extra: one overrun word, rst_at: cycle of a reset pulse (-1 none)
  // poke: start+ld_en during SEND, wr0: write img[0] together with start
  task automatic run_job(input string name, input int lat, input int nw, input int ovl,
                         input bit extra, input int rst_at, input bit poke,
                         input bit wr0, input bit opt);
    int          slen, done_c, n_res, n_done, got_res, ri, fall;
    logic [2:0]  exp_err;
    logic [31:0] e_img, e_k1, e_k2, e_w;
    bit          e_v, e_opt, e_rv, ov, hit_rst;

    fall  = IMG_LEN;
    n_res = (ovl >= 0) ? 0 : ((nw < OUT_LEN) ? nw : OUT_LEN);
    if (ovl >= 0) begin
      slen = ovl + 1; done_c = ovl + 1; exp_err = 3'b010;
    end else begin
      slen = IMG_LEN;
      if (nw == 0) begin
        done_c = fall + LAT_MAX; exp_err = 3'b001;
      end else if (nw < OUT_LEN) begin
        done_c = fall + lat + nw + 1; exp_err = 3'b100;
      end else begin
        done_c = fall + lat + OUT_LEN; exp_err = extra ? 3'b100 : 3'b000;
      end
    end

    start  = 1'b1;
    ld_opt = opt;
    if (wr0) begin
      ld_en = 1'b1; ld_sel = 2'd0; ld_addr = 7'd0; ld_data = $urandom();
      m_img[0] = ld_data;
    end
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    ld_en  = 1'b0;
    ld_opt = 1'($urandom_range(0, 1));

    n_done = 0; got_res = 0; hit_rst = 1'b0;
    for (int c = 0; c <= done_c + 2; c++) begin
      if (c == rst_at) begin
        rst_n = 1'b0; out_valid = 1'b0;
        #1;
        chk({name, " rst in_valid"},  32'(in_valid),  32'd0);
        chk({name, " rst Img"},       Img,            32'd0);
        chk({name, " rst Weight"},    Weight,         32'd0);
        chk({name, " rst res_valid"}, 32'(res_valid), 32'd0);
        chk({name, " rst res_data"},  res_data,       32'd0);
        chk({name, " rst busy"},      32'(busy),      32'd0);
        chk({name, " rst done"},      32'(done),      32'd0);
        chk({name, " rst err"},       32'(err),       32'd0);
        hit_rst = 1'b1;
        break;
      end
      e_v   = (c < slen);
      e_img = e_v ? m_img[c] : 32'd0;
      e_k1  = (e_v && c < KER_LEN) ? m_k1[c] : 32'd0;
      e_k2  = (e_v && c < KER_LEN) ? m_k2[c] : 32'd0;
      e_w   = (e_v && c < W_LEN) ? m_w[c] : 32'd0;
      e_opt = (c == 0) ? opt : 1'b0;
      chk($sformatf("%s c%0d in_valid", name, c), 32'(in_valid), 32'(e_v));
      chk($sformatf("%s c%0d Img", name, c), Img, e_img);
      chk($sformatf("%s c%0d Kernel_ch1", name, c), Kernel_ch1, e_k1);
      chk($sformatf("%s c%0d Kernel_ch2", name, c), Kernel_ch2, e_k2);
      chk($sformatf("%s c%0d Weight", name, c), Weight, e_w);
      chk($sformatf("%s c%0d Opt", name, c), 32'(Opt), 32'(e_opt));
      ri   = c - (fall + lat + 1);
      e_rv = (ovl < 0) && (ri >= 0) && (ri < n_res);
      chk($sformatf("%s c%0d res_valid", name, c), 32'(res_valid), 32'(e_rv));
      if (e_rv) begin
        chk($sformatf("%s c%0d res_idx", name, c), 32'(res_idx), 32'(ri));
        chk($sformatf("%s c%0d res_data", name, c), res_data, resp[ri]);
      end
      chk($sformatf("%s c%0d done", name, c), 32'(done), 32'(c == done_c));
      chk($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(c < done_c));
      if (c == 0) chk({name, " err cleared"}, 32'(err), 32'd0);
      if (res_valid) got_res++;
      if (done) n_done++;

      ov = (ovl >= 0) ? (c == ovl)
                      : (nw > 0 && c >= fall + lat && c < fall + lat + nw + int'(extra));
      out_valid = ov;
      out_word  = (ov && ovl < 0) ? resp[c - fall - lat] : $urandom();
      start     = poke && (c == 20);
      ld_en     = start;
      if (start) begin
        ld_sel  = 2'($urandom_range(0, 3));
        ld_addr = 7'($urandom_range(0, KER_LEN - 1));
        ld_data = $urandom();
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_valid = 1'b0; start = 1'b0; ld_en = 1'b0;

    if (hit_rst) begin
      repeat (2) begin
        @(posedge clk); @(negedge clk);
        chk({name, " in reset done"}, 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      repeat (3) begin
        @(posedge clk); @(negedge clk);
        chk({name, " after reset done"}, 32'(done), 32'd0);
        chk({name, " after reset busy"}, 32'(busy), 32'd0);
      end
      $display("job %-10s reset mid-RECV, outputs cleared", name);
    end else begin
      chk({name, " err"}, 32'(err), 32'(exp_err));
      chk({name, " done count"}, 32'(n_done), 32'd1);
      chk({name, " res count"}, 32'(got_res), 32'(n_res));
      $display("job %-10s lat=%0d words=%0d done@%0d err=%03b res=%0d",
               name, lat, nw, done_c, err, got_res);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_valid",  32'(in_valid),  32'd0);
    chk("reset Img",       Img,            32'd0);
    chk("reset Opt",       32'(Opt),       32'd0);
    chk("reset res_valid", 32'(res_valid), 32'd0);
    chk("reset busy",      32'(busy),      32'd0);
    chk("reset done",      32'(done),      32'd0);
    chk("reset err",       32'(err),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle busy", 32'(busy), 32'd0);

    load_buffers(1'b1);
    resp = '{32'hA, 32'hB, 32'hC, 32'hD};
    run_job("basic",      10, 3, -1, 1'b0, -1, 1'b0, 1'b0, 1'b1);
    run_job("timeout",    10, 0, -1, 1'b0, -1, 1'b0, 1'b0, 1'b1);
    run_job("overlap",    10, 3, 40, 1'b0, -1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) resp[i] = $urandom();
    run_job("gap",        10, 2, -1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    run_job("extra",       5, 3, -1, 1'b1, -1, 1'b0, 1'b0, 1'b1);
    run_job("poke",       $urandom_range(0, 60), 3, -1, 1'b0, -1, 1'b1, 1'b0, 1'b0);
    run_job("after_poke",  7, 3, -1, 1'b0, -1, 1'b0, 1'b1, 1'b1);
    run_job("reset",      10, 3, -1, 1'b0, IMG_LEN + 11, 1'b0, 1'b0, 1'b1);
    run_job("post_reset",  0, 3, -1, 1'b0, -1, 1'b0, 1'b0, 1'b1);

    load_buffers(1'b0);
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 4; i++) resp[i] = $urandom();
      run_job("random", $urandom_range(0, 60), 3, -1, 1'b0, -1, 1'b0, 1'b0,
              1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
